// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multi-cycle sequencer for an RV32I R-type core.
// Fetches one instruction at a time over a req/ack handshake, decodes it into
// a 4-bit ALU code, and strobes the register-file write enable for one WB cycle.
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> an illegal instruction halts the core with oTrap=1, PC frozen
//   undefined -> an illegal instruction is skipped as a NOP, oTrap tied 0
module rv32i_multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iRun,
    output logic        oImem_Req,
    output logic [31:0] oImem_Addr,
    input  logic        iImem_Ack,
    input  logic [31:0] iImem_Data,
    output logic [31:0] oInst,
    output logic [3:0]  oAlu_Ctrl,
    output logic        oRf_WrEn,
    output logic        oRetire,
    output logic [31:0] oPC,
    output logic        oBusy,
    output logic        oTrap
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0]  OPC_OP = 7'b0110011;
    localparam logic [31:0] STEP   = 32'(PC_STEP);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [3:0]  alu_q, alu_d;
    logic        req_q, req_d;
    logic        busy_q, busy_d;
    logic        wren_q, wren_d;
    logic        retire_q, retire_d;
    logic        dec_legal;
    logic [3:0]  dec_code;

    // R-type decode of the latched instruction, keyed on {funct7, funct3}
    always_comb begin
        dec_legal = 1'b0;
        dec_code  = 4'b0000;
        if (inst_q[6:0] == OPC_OP) begin
            unique case ({inst_q[31:25], inst_q[14:12]})
                10'b0000000_000: begin dec_legal = 1'b1; dec_code = 4'b0000; end // ADD
                10'b0100000_000: begin dec_legal = 1'b1; dec_code = 4'b0001; end // SUB
                10'b0000000_001: begin dec_legal = 1'b1; dec_code = 4'b0010; end // SLL
                10'b0000000_101: begin dec_legal = 1'b1; dec_code = 4'b0011; end // SRL
                10'b0100000_101: begin dec_legal = 1'b1; dec_code = 4'b0100; end // SRA
                10'b0000000_010: begin dec_legal = 1'b1; dec_code = 4'b0101; end // SLT
                10'b0000000_011: begin dec_legal = 1'b1; dec_code = 4'b0110; end // SLTU
                10'b0000000_100: begin dec_legal = 1'b1; dec_code = 4'b0111; end // XOR
                10'b0000000_110: begin dec_legal = 1'b1; dec_code = 4'b1000; end // OR
                10'b0000000_111: begin dec_legal = 1'b1; dec_code = 4'b1001; end // AND
                default:         begin dec_legal = 1'b0; dec_code = 4'b0000; end
            endcase
        end
    end

    // Next-state and next-output logic; strobes are derived from the next
    // state so that every output leaves the flops aligned with its state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        alu_d   = alu_q;
        unique case (state_q)
            S_IDLE: begin
                if (iRun) state_d = S_FETCH;
            end
            S_FETCH: begin
                // iRun is ignored: a started fetch always completes
                if (req_q && iImem_Ack) begin
                    inst_d  = iImem_Data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    alu_d   = dec_code;
                    state_d = S_EXEC;
                end else begin
                    alu_d = 4'b0000;
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    pc_d    = pc_q + STEP;
                    state_d = iRun ? S_FETCH : S_IDLE;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = pc_q + STEP;
                state_d = iRun ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_d    = (state_d == S_FETCH);
        busy_d   = (state_d != S_IDLE);
        retire_d = (state_d == S_WB);
        wren_d   = (state_d == S_WB) && (inst_d[11:7] != 5'd0);
    end

    // State and registered outputs; reset drops any pending fetch
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= 32'd0;
            alu_q    <= 4'b0000;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            wren_q   <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            alu_q    <= alu_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            wren_q   <= wren_d;
            retire_q <= retire_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;

    // Sticky trap flag: set on entry to HALT, cleared only by reset
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) trap_q <= 1'b0;
        else         trap_q <= (state_d == S_HALT);
    end

    assign oTrap = trap_q;
`else
    assign oTrap = 1'b0;
`endif

    assign oImem_Req  = req_q;
    assign oImem_Addr = pc_q;
    assign oInst      = inst_q;
    assign oAlu_Ctrl  = alu_q;
    assign oRf_WrEn   = wren_q;
    assign oRetire    = retire_q;
    assign oPC        = pc_q;
    assign oBusy      = busy_q;

endmodule
